alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode/issue stage that drives the ALU.
- Accepts fetched RV32I words (OP, OP-IMM, LUI, AUIPC) over a valid/ready handshake.
- Reads the register file, resolves RAW/WAW hazards with a 32-entry pending-write scoreboard, and registers ALU controls plus operands toward execute.
- The ALU is the consumer; this block is the producer of its op/alt_op/operand fields.

Parameters:
XLEN, 32, data/operand width; only 32 is supported
NREGS, 32, architectural register count; also the scoreboard depth

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
in_valid_i  in  1  fetch word valid
in_ready_o  out  1  stage accepts fetch word this cycle
instr_i  in  32  instruction word
pc_i  in  32  instruction address
rs1_addr_o  out  5  regfile read address 1 (combinational from instr_i[19:15])
rs2_addr_o  out  5  regfile read address 2 (combinational from instr_i[24:20])
rs1_data_i  in  32  regfile read data 1, same cycle
rs2_data_i  in  32  regfile read data 2, same cycle
out_valid_o  out  1  issue beat valid
out_ready_i  in  1  execute accepts beat
op_o  out  3  ALU funct3
alt_op_o  out  1  SUB/SRA select
operand1_o  out  32  ALU operand 1
operand2_o  out  32  ALU operand 2
rd_o  out  5  destination register
rd_we_o  out  1  destination write enable
wb_valid_i  in  1  writeback retires a register write
wb_rd_i  in  5  retiring destination
flush_i  in  1  squash output register and refuse input this cycle

Behaviour:
- Reset (async, rstn_i low):
  - out_valid_o=0.
  - op_o, alt_op_o, operand1_o, operand2_o, rd_o and rd_we_o all reset to 0.
  - Scoreboard is all-clear.
- Latency: a word accepted in cycle N is presented with out_valid_o=1 in cycle N+1.
- Output register:
  - Holds its value while out_valid_o && !out_ready_i.
  - All outputs remain stable while stalled.
- hazard:
  - Asserted when any used source is nonzero and its scoreboard bit is set, or it equals rd_o while out_valid_o && rd_we_o.
  - Also asserted for a nonzero rd under the same two conditions (WAW).
  - LUI/AUIPC use no sources; OP-IMM uses rs1 only.
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i.
- Scoreboard:
  - Bit rd_o is set on an execute handshake (out_valid_o && out_ready_i && rd_we_o && rd_o!=0).
  - Bit wb_rd_i is cleared when wb_valid_i.
  - Set and clear of the same index in the same cycle: set wins.
  - Bit 0 is never set.
- Decode:
  - OP (0110011):
    - op=funct3, alt=instr[30].
    - opnd1=rs1.
    - opnd2=rs2; for funct3 001/101, opnd2 = {27'b0, rs2[4:0]}.
    - Legal only if funct7 is 0000000, or funct7 is 0100000 with funct3 000/101.
  - OP-IMM (0010011):
    - op=funct3, opnd1=rs1, opnd2=sign-extended imm[11:0].
    - alt=instr[30] only for funct3 101, else 0.
    - Shifts: opnd2 = {27'b0, shamt}; funct7 legality same as OP with the 101 alt case only.
  - LUI: op=000, alt=0, opnd1=0, opnd2={instr[31:12],12'b0}.
  - AUIPC: op=000, alt=0, opnd1=pc_i, opnd2={instr[31:12],12'b0}.
  - Any source register x0 yields operand 0 regardless of rs*_data_i.
  - rd_we=1 for legal words with rd!=0.
- Flush:
  - flush_i clears out_valid_o next cycle; no input is accepted that cycle.
  - Scoreboard is not touched.
  - flush_i with out_ready_i in the same cycle: the handshake completes and sets the scoreboard; flush then clears valid.
- Reset mid-operation: output beat and all pending bits are discarded immediately.

Optional Feature:
- Macro: RV32I_ILLEGAL_TRAP_EN.
- Defined:
  - Adds port illegal_o (out, 1, reset 0).
  - An illegal word is issued as a beat with illegal_o=1, rd_we_o=0, op_o=000, operands 0.
- Undefined:
  - No illegal_o port.
  - An illegal word is accepted and dropped: no output beat and no scoreboard change.

Test Plan:
- ADDI x1,x0,-5 with out_ready_i=1 -> next cycle op_o=000, alt_op_o=0, operand1_o=0, operand2_o=0xFFFFFFFB, rd_o=1, rd_we_o=1.
- SUB x3,x1,x2 with rs1=10, rs2=3 -> alt_op_o=1, operands 10/3; SRA with rs2=0x00000024 -> operand2_o=4.
- ADDI x1 followed by ADD x2,x1,x1 with no writeback -> in_ready_o=0 until wb_valid_i with wb_rd_i=1; second beat issues one cycle after the clear is registered.
- out_ready_i=0 for 3 cycles with a valid beat -> out_valid_o held and outputs unchanged; in_ready_o=0; beat transfers on the first out_ready_i=1.
- flush_i pulsed while a beat is stalled -> out_valid_o=0 next cycle and scoreboard bit for rd_o stays clear; LUI x5,0x12345 afterward -> operand2_o=0x12345000.
- Word 0xFFFFFFFF:
  - With RV32I_ILLEGAL_TRAP_EN defined -> illegal_o=1, rd_we_o=0.
  - Without the macro -> accepted, out_valid_o stays 0.

Source files
------------

// File: rtl/alu_issue.sv
// RV32I decode/issue stage feeding the ALU: handshake in, scoreboard hazard check, registered ALU controls out.
// Optional RV32I_ILLEGAL_TRAP_EN: issue illegal words as marked beats (illegal_o) instead of dropping them.
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [31:0]     pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [2:0]      op_o,
    output logic            alt_op_o,
    output logic [XLEN-1:0] operand1_o,
    output logic [XLEN-1:0] operand2_o,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic            flush_i
`ifdef RV32I_ILLEGAL_TRAP_EN
    ,
    output logic            illegal_o
`endif
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    function automatic logic [XLEN-1:0] shamt_ext(input logic [4:0] sh);
        return {{(XLEN-5){1'b0}}, sh};
    endfunction

    function automatic logic reg_busy(input logic [4:0] r, input logic [NREGS-1:0] sb,
                                      input logic pend_vld, input logic [4:0] pend_rd);
        return (r != 5'd0) && (sb[r] || (pend_vld && (pend_rd == r)));
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;

    assign opcode     = instr_i[6:0];
    assign rd         = instr_i[11:7];
    assign funct3     = instr_i[14:12];
    assign rs1        = instr_i[19:15];
    assign rs2        = instr_i[24:20];
    assign funct7     = instr_i[31:25];
    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    logic            vld_p1;
    logic [2:0]      op_p1;
    logic            alt_p1;
    logic [XLEN-1:0] opnd1_p1, opnd2_p1;
    logic [4:0]      rd_p1;
    logic            rd_we_p1;
    logic            illegal_p1;
    logic [NREGS-1:0] pending, pending_next;

    logic            use_rs1, use_rs2, legal, d_we, d_alt;
    logic [2:0]      d_op;
    logic [XLEN-1:0] rs1_val, rs2_val, d_opnd1, d_opnd2;

    // x0 reads as zero whatever the register file returns
    assign rs1_val = (rs1 == 5'd0) ? '0 : rs1_data_i;
    assign rs2_val = (rs2 == 5'd0) ? '0 : rs2_data_i;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        legal   = 1'b0;
        d_op    = 3'b000;
        d_alt   = 1'b0;
        d_opnd1 = '0;
        d_opnd2 = '0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                legal   = (funct7 == 7'd0) ||
                          ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                d_op    = funct3;
                d_alt   = instr_i[30];
                d_opnd1 = rs1_val;
                d_opnd2 = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? shamt_ext(rs2_val[4:0]) : rs2_val;
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1;
                d_op    = funct3;
                d_opnd1 = rs1_val;
                if (funct3 == 3'b001) begin
                    legal   = (funct7 == 7'd0);
                    d_opnd2 = shamt_ext(instr_i[24:20]);
                end else if (funct3 == 3'b101) begin
                    legal   = (funct7 == 7'd0) || (funct7 == F7_ALT);
                    d_alt   = instr_i[30];
                    d_opnd2 = shamt_ext(instr_i[24:20]);
                end else begin
                    legal   = 1'b1;
                    d_opnd2 = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                end
            end
            OPC_LUI: begin
                legal   = 1'b1;
                d_opnd2 = {instr_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                d_opnd1 = pc_i;
                d_opnd2 = {instr_i[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        d_we = legal && (rd != 5'd0);
    end

    logic hazard, accept, issue, fire_out;

    // the beat still in the output register has not reached the scoreboard yet
    assign hazard = (use_rs1 && reg_busy(rs1, pending, vld_p1 && rd_we_p1, rd_p1)) ||
                    (use_rs2 && reg_busy(rs2, pending, vld_p1 && rd_we_p1, rd_p1)) ||
                    (d_we    && reg_busy(rd,  pending, vld_p1 && rd_we_p1, rd_p1));

    assign in_ready_o = (!vld_p1 || out_ready_i) && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign fire_out   = vld_p1 && out_ready_i;
`ifdef RV32I_ILLEGAL_TRAP_EN
    assign issue = accept;
`else
    assign issue = accept && legal;
`endif

    always_comb begin
        pending_next = pending;
        if (wb_valid_i)
            pending_next[wb_rd_i] = 1'b0;
        if (fire_out && rd_we_p1 && (rd_p1 != 5'd0))
            pending_next[rd_p1] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            pending <= '0;
        else
            pending <= pending_next;
    end

    // stage p1: output register toward execute
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p1     <= 1'b0;
            op_p1      <= 3'b000;
            alt_p1     <= 1'b0;
            opnd1_p1   <= '0;
            opnd2_p1   <= '0;
            rd_p1      <= 5'd0;
            rd_we_p1   <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= issue;
            if (issue) begin
                op_p1      <= legal ? d_op : 3'b000;
                alt_p1     <= legal && d_alt;
                opnd1_p1   <= legal ? d_opnd1 : '0;
                opnd2_p1   <= legal ? d_opnd2 : '0;
                rd_p1      <= legal ? rd : 5'd0;
                rd_we_p1   <= d_we;
                illegal_p1 <= !legal;
            end
        end else if (out_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid_o = vld_p1;
    assign op_o        = op_p1;
    assign alt_op_o    = alt_p1;
    assign operand1_o  = opnd1_p1;
    assign operand2_o  = opnd2_p1;
    assign rd_o        = rd_p1;
    assign rd_we_o     = rd_we_p1;
`ifdef RV32I_ILLEGAL_TRAP_EN
    assign illegal_o   = illegal_p1;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_p1;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: table vectors, hand sequences for hazards/stall/flush/reset, random words vs a reference model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] instr = 32'd0, pc = 32'd0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid, out_ready = 1'b0;
    logic [2:0]  op;
    logic        alt_op;
    logic [31:0] operand1, operand2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic        flush = 1'b0;
    logic        illegal;

    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    alu_issue dut (
        .clk_i(clk), .rstn_i(rstn),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .op_o(op), .alt_op_o(alt_op),
        .operand1_o(operand1), .operand2_o(operand2),
        .rd_o(rd), .rd_we_o(rd_we),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .flush_i(flush)
`ifdef RV32I_ILLEGAL_TRAP_EN
        , .illegal_o(illegal)
`endif
    );
`ifndef RV32I_ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic        alt;
        logic [31:0] o1, o2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } beat_t;

    typedef struct {
        string       name;
        logic [31:0] ins, pc, r1, r2;
        beat_t       exp;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cmp_beat(input string name, input beat_t got, input beat_t exp);
        chk({name, ".valid"}, 32'(got.valid), 32'(exp.valid));
        if (exp.valid) begin
            chk({name, ".op"},  32'(got.op),  32'(exp.op));
            chk({name, ".alt"}, 32'(got.alt), 32'(exp.alt));
            chk({name, ".o1"},  got.o1, exp.o1);
            chk({name, ".o2"},  got.o2, exp.o2);
            chk({name, ".rd"},  32'(got.rd),  32'(exp.rd));
            chk({name, ".we"},  32'(got.we),  32'(exp.we));
            chk({name, ".ill"}, 32'(got.ill), 32'(exp.ill));
        end
    endtask

    // Reference: what execute should see for one word, straight from the ISA rules.
    function automatic beat_t model(input logic [31:0] ins, input logic [31:0] pcv);
        beat_t b;
        int unsigned f3, f7, opc, rdn, s1, s2, imm;
        logic [31:0] v1, v2;
        logic ok;
        opc = ins & 32'h7F;
        rdn = (ins >> 7) & 32'h1F;
        f3  = (ins >> 12) & 32'h7;
        s1  = (ins >> 15) & 32'h1F;
        s2  = (ins >> 20) & 32'h1F;
        f7  = ins >> 25;
        imm = ins >> 20;
        v1  = (s1 == 0) ? 32'd0 : regs[s1];
        v2  = (s2 == 0) ? 32'd0 : regs[s2];
        b = '{valid: 1'b1, op: 3'd0, alt: 1'b0, o1: 32'd0, o2: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b0};
        ok = 1'b0;
        if (opc == 'h33) begin
            ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
            b.op = 3'(f3); b.alt = (f7 == 'h20); b.o1 = v1;
            b.o2 = (f3 == 1 || f3 == 5) ? (v2 % 32) : v2;
        end else if (opc == 'h13) begin
            b.op = 3'(f3); b.o1 = v1;
            if (f3 == 1) begin
                ok = (f7 == 0); b.o2 = s2;
            end else if (f3 == 5) begin
                ok = (f7 == 0 || f7 == 'h20); b.o2 = s2; b.alt = (f7 == 'h20);
            end else begin
                ok = 1'b1;
                b.o2 = (imm >= 2048) ? imm + 32'hFFFFF000 : imm;
                b.alt = ins[30] && 1'b0;
            end
        end else if (opc == 'h37 || opc == 'h17) begin
            ok = 1'b1;
            b.o2 = ins & 32'hFFFFF000;
            b.o1 = (opc == 'h17) ? pcv : 32'd0;
        end
        if (ok) begin
            b.rd = 5'(rdn);
            b.we = (rdn != 0);
        end else begin
            b = '{valid: 1'b0, op: 3'd0, alt: 1'b0, o1: 32'd0, o2: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b1};
`ifdef RV32I_ILLEGAL_TRAP_EN
            b.valid = 1'b1;
`endif
        end
        return b;
    endfunction

    task automatic wb_pulse(input logic [4:0] r);
        wb_valid = 1'b1; wb_rd = r;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    // Called just after a posedge: offers one word, captures the beat, drains it and retires its rd.
    task automatic issue(input string name, input logic [31:0] ins, input logic [31:0] pcv, output beat_t got);
        int n = 0;
        in_valid = 1'b1; instr = ins; pc = pcv; out_ready = 1'b0;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk({name, ".ready_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = '{valid: out_valid, op: op, alt: alt_op, o1: operand1, o2: operand2, rd: rd, we: rd_we, ill: illegal};
        if (out_valid) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (rd_we) wb_pulse(rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    vec_t  vecs [10];
    beat_t got, exp;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[0] = 32'hDEADBEEF;

        vecs[0] = '{"addi_neg", 32'hFFB00093, 32'h0, 32'd0, 32'd0,
                    '{1'b1, 3'd0, 1'b0, 32'h0, 32'hFFFFFFFB, 5'd1, 1'b1, 1'b0}};
        vecs[1] = '{"sub", 32'h402081B3, 32'h0, 32'd10, 32'd3,
                    '{1'b1, 3'd0, 1'b1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0}};
        vecs[2] = '{"sra", 32'h4020D233, 32'h0, 32'h80000000, 32'h24,
                    '{1'b1, 3'd5, 1'b1, 32'h80000000, 32'd4, 5'd4, 1'b1, 1'b0}};
        vecs[3] = '{"lui", 32'h123452B7, 32'h0, 32'd0, 32'd0,
                    '{1'b1, 3'd0, 1'b0, 32'h0, 32'h12345000, 5'd5, 1'b1, 1'b0}};
        vecs[4] = '{"auipc", 32'h00001317, 32'h100, 32'd0, 32'd0,
                    '{1'b1, 3'd0, 1'b0, 32'h100, 32'h1000, 5'd6, 1'b1, 1'b0}};
        vecs[5] = '{"add_x0", 32'h002003B3, 32'h0, 32'd0, 32'h1234,
                    '{1'b1, 3'd0, 1'b0, 32'h0, 32'h1234, 5'd7, 1'b1, 1'b0}};
        vecs[6] = '{"srai", 32'h4030D413, 32'h0, 32'hF0, 32'd0,
                    '{1'b1, 3'd5, 1'b1, 32'hF0, 32'd3, 5'd8, 1'b1, 1'b0}};
        vecs[7] = '{"addi_rd0", 32'h00508013, 32'h0, 32'd1, 32'd0,
                    '{1'b1, 3'd0, 1'b0, 32'd1, 32'd5, 5'd0, 1'b0, 1'b0}};
        vecs[8] = '{"xori", 32'hFFF0C493, 32'h0, 32'd5, 32'd0,
                    '{1'b1, 3'd4, 1'b0, 32'd5, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0}};
        vecs[9] = '{"sll", 32'h00209533, 32'h0, 32'd7, 32'h25,
                    '{1'b1, 3'd1, 1'b0, 32'd7, 32'd5, 5'd10, 1'b1, 1'b0}};

        // reset state
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.operands", operand1 | operand2, 32'd0);
        chk("rst.ctrl", {21'd0, op, alt_op, rd, rd_we, illegal}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].ins[19:15] != 5'd0) regs[vecs[i].ins[19:15]] = vecs[i].r1;
            if (vecs[i].ins[24:20] != 5'd0) regs[vecs[i].ins[24:20]] = vecs[i].r2;
            issue(vecs[i].name, vecs[i].ins, vecs[i].pc, got);
            cmp_beat(vecs[i].name, got, vecs[i].exp);
        end

        // RAW hazard on x1 held until writeback retires it
        regs[1] = 32'h55;
        in_valid = 1'b1; instr = 32'hFFB00093; out_ready = 1'b1;
        #1 chk("raw.first_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        instr = 32'h00108133;
        #1 chk("raw.inflight_block", 32'(in_ready), 32'd0);
        chk("raw.first_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("raw.drained", 32'(out_valid), 32'd0);
        chk("raw.sb_block", 32'(in_ready), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("raw.still_block", 32'(in_ready), 32'd0);
        end
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1 chk("raw.wb_cycle_block", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        #1 chk("raw.released", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("raw.second_valid", 32'(out_valid), 32'd1);
        chk("raw.second_rd", 32'(rd), 32'd2);
        chk("raw.second_o1", operand1, 32'h55);
        chk("raw.second_o2", operand2, 32'h55);
        @(posedge clk); #1;
        out_ready = 1'b0;
        wb_pulse(5'd2);

        // output stall holds the beat
        in_valid = 1'b1; instr = 32'h123452B7; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall.valid", 32'(out_valid), 32'd1);
            chk("stall.o2", operand2, 32'h12345000);
            chk("stall.rd", 32'(rd), 32'd5);
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall.transferred", 32'(out_valid), 32'd0);
        wb_pulse(5'd5);

        // flush of a stalled beat leaves the scoreboard alone
        in_valid = 1'b1; instr = 32'h00100413;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flush.pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        #1 chk("flush.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.cleared", 32'(out_valid), 32'd0);
        instr = 32'h008404B3;
        #1 chk("flush.sb_clear", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        issue("flush.lui", 32'h123452B7, 32'h0, got);
        chk("flush.lui_o2", got.o2, 32'h12345000);

        // flush with a same-cycle handshake still marks rd pending
        in_valid = 1'b1; instr = 32'h00700513;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flushhs.cleared", 32'(out_valid), 32'd0);
        instr = 32'h000505B3;
        #1 chk("flushhs.sb_set", 32'(in_ready), 32'd0);
        wb_pulse(5'd10);
        #1 chk("flushhs.wb_clear", 32'(in_ready), 32'd1);

        // all-ones word
        issue("illegal", 32'hFFFFFFFF, 32'h0, got);
        cmp_beat("illegal", got, model(32'hFFFFFFFF, 32'h0));
`ifdef RV32I_ILLEGAL_TRAP_EN
        chk("illegal.flag", 32'(got.ill), 32'd1);
        chk("illegal.we", 32'(got.we), 32'd0);
`else
        chk("illegal.dropped", 32'(got.valid), 32'd0);
`endif

        // reset mid-operation discards beat and pending bits
        in_valid = 1'b1; instr = 32'h00300613; out_ready = 1'b1;
        @(posedge clk); #1;
        instr = 32'h00400693;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rstmid.valid", 32'(out_valid), 32'd1);
        instr = 32'h00060733;
        #1 chk("rstmid.sb_block", 32'(in_ready), 32'd0);
        rstn = 1'b0;
        #1;
        chk("rstmid.valid_gone", 32'(out_valid), 32'd0);
        chk("rstmid.rd_zero", 32'(rd), 32'd0);
        chk("rstmid.sb_gone", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // random words against the reference model
        for (int it = 0; it < 60; it++) begin
            logic [31:0] w, pcv;
            int unsigned kind, f3;
            for (int r = 1; r < 32; r++) regs[r] = $urandom;
            pcv  = $urandom & 32'hFFFFFFFC;
            kind = $urandom_range(0, 4);
            f3   = $urandom_range(0, 7);
            w    = $urandom;
            case (kind)
                0: begin
                    w[6:0] = 7'h33; w[14:12] = 3'(f3);
                    w[31:25] = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                1: begin
                    w[6:0] = 7'h13; w[14:12] = 3'(f3);
                    if (f3 == 1) w[31:25] = 7'h00;
                    if (f3 == 5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                2: w[6:0] = 7'h37;
                3: w[6:0] = 7'h17;
                default: ;
            endcase
            exp = model(w, pcv);
            issue("random", w, pcv, got);
            cmp_beat("random", got, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
